fc_mac_stream: RTL and testbench

Parametrised fully-connected neuron engine. Computes one output activation as out = sat(act(sum_{k<N_IN} x[k]*w[k] + b)) by streaming LANES input/weight pairs per beat through a valid/ready handshake into a wide accumulator. Sits after the last pooling stage and feeds the classifier output buffer. One instance is used per output neuron, or one instance is time-shared across neurons.

---
 rtl/fc_pkg.sv | 37 +++
 rtl/fc_mac_stream_if.sv | 29 ++
 rtl/fc_lane_dot.sv | 32 +++
 rtl/fc_mac_stream.sv | 127 ++++++++++++
 tb/tb_fc_mac_stream.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected MAC engine:
// controller states, default widths and the output saturation function.
package fc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      BIAS,
      OUT
   } state_t;

   localparam int DEF_IN_W = 30;
   localparam int DEF_W_W  = 9;
   localparam int DEF_B_W  = 9;

   // Working width of the saturation helper; callers sign-extend into it
   localparam int SAT_W = 128;

   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] val,
      input int                      out_w
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      for (int i = 0; i < SAT_W; i++) begin
         hi[i] = (i < out_w - 1);
      end
      lo = ~hi;
      if (val > hi) begin
         return hi;
      end else if (val < lo) begin
         return lo;
      end
      return val;
   endfunction

endpackage

// File: rtl/fc_mac_stream_if.sv
// Beat input and result output handshakes of the fully-connected MAC engine.
interface fc_mac_stream_if
   import fc_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_W  = DEF_IN_W,
   parameter int W_W   = DEF_W_W,
   parameter int OUT_W = 38
);

   logic                     in_valid;
   logic                     in_ready;
   logic [LANES*IN_W-1:0]    in_data;
   logic [LANES*W_W-1:0]     w_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;

   modport master (
      output in_valid, in_data, w_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, w_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/fc_lane_dot.sv
// Combinational LANES-wide signed dot product of one beat, each product
// sign-extended to the accumulator width before the adder tree.
module fc_lane_dot
   import fc_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int W_W   = DEF_W_W,
   parameter int LANES = 4,
   parameter int ACC_W = 52
) (
   input  logic [LANES*IN_W-1:0]   in_data,
   input  logic [LANES*W_W-1:0]    w_data,
   output logic signed [ACC_W-1:0] dot
);

   localparam int PROD_W = IN_W + W_W;

   logic signed [PROD_W-1:0] prod [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign prod[l] = PROD_W'($signed(in_data[l*IN_W +: IN_W]))
                     * PROD_W'($signed(w_data[l*W_W +: W_W]));
   end

   always_comb begin
      dot = '0;
      for (int l = 0; l < LANES; l++) begin
         dot = dot + ACC_W'(prod[l]);
      end
   end

endmodule

// File: rtl/fc_mac_stream.sv
// Streaming fully-connected neuron: accumulates N_IN products LANES per beat,
// adds the bias, optionally applies ReLU and saturates to OUT_W.
module fc_mac_stream
   import fc_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int W_W   = DEF_W_W,
   parameter int B_W   = DEF_B_W,
   parameter int N_IN  = 3136,
   parameter int LANES = 4,
   parameter int ACC_W = 52,
   parameter int OUT_W = 38,
   parameter int RELU  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic signed [B_W-1:0] bias,
   output logic                  busy,
   output logic                  done,
   fc_mac_stream_if.slave        bus
);

   localparam int BEATS = N_IN / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   if ((N_IN % LANES) != 0) begin : g_lanes_chk
      $error("fc_mac_stream: N_IN must be a multiple of LANES");
   end
   if (ACC_W < IN_W + W_W + $clog2(N_IN) + 1) begin : g_acc_chk
      $error("fc_mac_stream: ACC_W too narrow for IN_W, W_W and N_IN");
   end
   if (ACC_W + 1 > SAT_W) begin : g_sat_chk
      $error("fc_mac_stream: ACC_W exceeds saturation helper width");
   end

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic signed [B_W-1:0]   bias_q;
   logic signed [ACC_W-1:0] dot;
   logic signed [ACC_W:0]   sum_b;

   fc_lane_dot #(
      .IN_W  (IN_W),
      .W_W   (W_W),
      .LANES (LANES),
      .ACC_W (ACC_W)
   ) u_dot (
      .in_data (bus.in_data),
      .w_data  (bus.w_data),
      .dot     (dot)
   );

   // One guard bit so acc + bias cannot wrap before saturation
   always_comb begin
      sum_b = (ACC_W+1)'(acc) + (ACC_W+1)'(bias_q);
      if (RELU != 0 && sum_b < 0) begin
         sum_b = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         bias_q        <= '0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         // abort outranks start, beats and the output handshake alike
         if (abort) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     acc          <= '0;
                     cnt          <= '0;
                     bias_q       <= bias;
                     state        <= ACCUM;
                     bus.in_ready <= 1'b1;
                     busy         <= 1'b1;
                  end
               end
               ACCUM: begin
                  if (bus.in_valid) begin
                     acc <= acc + dot;
                     cnt <= cnt + CNT_W'(1);
                     if (cnt == LAST) begin
                        state        <= BIAS;
                        bus.in_ready <= 1'b0;
                     end
                  end
               end
               BIAS: begin
                  bus.out_data  <= OUT_W'(saturate(SAT_W'(sum_b), OUT_W));
                  bus.out_valid <= 1'b1;
                  state         <= OUT;
               end
               OUT: begin
                  if (bus.out_ready) begin
                     bus.out_valid <= 1'b0;
                     done          <= 1'b1;
                     busy          <= 1'b0;
                     state         <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fc_mac_stream.sv
// Bench for fc_mac_stream: two instances (RELU off/on) share all stimulus;
// results are compared with a plain-arithmetic neuron model.
module tb_fc_mac_stream;

   localparam int N_IN  = 8;
   localparam int LANES = 4;
   localparam int IN_W  = 30;
   localparam int W_W   = 9;
   localparam int OUT_W = 16;

   typedef int vec_t [8];

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic signed [8:0] bias;
   logic              busy0, busy1, done0, done1;

   int checks = 0;
   int errors = 0;
   int cur_bias;

   fc_mac_stream_if #(.LANES(LANES), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)) bus0 ();
   fc_mac_stream_if #(.LANES(LANES), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)) bus1 ();

   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.in_data   = bus0.in_data;
   assign bus1.w_data    = bus0.w_data;
   assign bus1.out_ready = bus0.out_ready;

   fc_mac_stream #(.N_IN(N_IN), .LANES(LANES), .OUT_W(OUT_W), .RELU(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
      .busy(busy0), .done(done0), .bus(bus0)
   );

   fc_mac_stream #(.N_IN(N_IN), .LANES(LANES), .OUT_W(OUT_W), .RELU(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
      .busy(busy1), .done(done1), .bus(bus1)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint model(input vec_t xs, input vec_t ws, input int b, input bit relu);
      longint s;
      s = longint'(b);
      for (int k = 0; k < N_IN; k++) s += longint'(xs[k]) * longint'(ws[k]);
      if (relu && s < 0) s = 0;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic drive_beat(input vec_t xs, input vec_t ws, input int k);
      bus0.in_valid = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         bus0.in_data[l*IN_W +: IN_W] = 30'(xs[k*LANES+l]);
         bus0.w_data[l*W_W +: W_W]    = 9'(ws[k*LANES+l]);
      end
   endtask

   task automatic start_neuron(input int b);
      start    = 1'b1;
      bias     = 9'(b);
      cur_bias = b;
      tick();
      start = 1'b0;
      chk_bit("in_ready_after_start", bus0.in_ready, 1'b1);
      chk_bit("busy_after_start", busy0, 1'b1);
   endtask

   task automatic feed(input string tag, input vec_t xs, input vec_t ws,
                       input bit toggle, output longint e0);
      for (int k = 0; k < N_IN/LANES; k++) begin
         if (toggle) begin
            bus0.in_valid = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk_bit("stall_in_ready", bus0.in_ready, 1'b1);
         end
         drive_beat(xs, ws, k);
         tick();
         bus0.in_valid = 1'b0;
         chk_bit("in_ready_after_beat", bus0.in_ready, (k < N_IN/LANES-1));
         chk_bit("out_valid_early", bus0.out_valid, 1'b0);
      end
      tick();
      e0 = model(xs, ws, cur_bias, 1'b0);
      chk_bit({tag, "_out_valid"}, bus0.out_valid, 1'b1);
      chk_val({tag, "_data"}, 64'(bus0.out_data), e0);
      chk_val({tag, "_data_relu"}, 64'(bus1.out_data), model(xs, ws, cur_bias, 1'b1));
   endtask

   task automatic finish(input int hold, input longint e0);
      for (int i = 0; i < hold; i++) begin
         start = 1'b1;
         bus0.in_valid = 1'b1;
         tick();
         chk_bit("hold_out_valid", bus0.out_valid, 1'b1);
         chk_val("hold_data", 64'(bus0.out_data), e0);
         chk_bit("hold_no_done", done0, 1'b0);
         chk_bit("hold_in_ready", bus0.in_ready, 1'b0);
      end
      start = 1'b0;
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      tick();
      bus0.out_ready = 1'b0;
      chk_bit("done_pulse", done0, 1'b1);
      chk_bit("out_valid_drop", bus0.out_valid, 1'b0);
      chk_bit("busy_drop", busy0, 1'b0);
      chk_val("data_kept", 64'(bus0.out_data), e0);
   endtask

   task automatic run(input string tag, input vec_t xs, input vec_t ws, input int b,
                      input bit toggle, input int hold);
      longint e0;
      start_neuron(b);
      feed(tag, xs, ws, toggle, e0);
      finish(hold, e0);
      tick();
      chk_bit({tag, "_done_one_cycle"}, done0, 1'b0);
   endtask

   initial begin
      vec_t   xs, ws, xs2, ws2;
      longint e0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; bias = '0;
      bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.w_data = '0; bus0.out_ready = 1'b0;
      tick();
      chk_bit("rst_in_ready", bus0.in_ready, 1'b0);
      chk_bit("rst_out_valid", bus0.out_valid, 1'b0);
      chk_val("rst_out_data", 64'(bus0.out_data), 64'(0));
      chk_bit("rst_busy", busy0, 1'b0);
      chk_bit("rst_done", done0, 1'b0);
      rst_n = 1'b1;
      tick();

      // basic, signed with bias, saturation both ways
      for (int k = 0; k < N_IN; k++) begin xs[k] = 1; ws[k] = 1; end
      run("basic", xs, ws, 0, 1'b0, 0);
      for (int k = 0; k < N_IN; k++) begin xs[k] = -3; ws[k] = 5; end
      run("signed_bias", xs, ws, -9, 1'b0, 1);
      for (int k = 0; k < N_IN; k++) begin xs[k] = 536870911; ws[k] = 255; end
      run("sat_pos", xs, ws, 0, 1'b0, 0);
      for (int k = 0; k < N_IN; k++) begin xs[k] = -536870912; ws[k] = 255; end
      run("sat_neg", xs, ws, 0, 1'b0, 0);

      // backpressure on both sides, start/in_valid ignored outside their states
      for (int k = 0; k < N_IN; k++) begin xs[k] = k + 1; ws[k] = 2; end
      run("backpressure", xs, ws, 3, 1'b1, 5);

      // abort after first beat, beat presented alongside abort is dropped
      for (int k = 0; k < N_IN; k++) begin xs[k] = 1; ws[k] = 1; end
      start_neuron(0);
      drive_beat(xs, ws, 0);
      tick();
      abort = 1'b1;
      drive_beat(xs, ws, 1);
      tick();
      abort = 1'b0;
      bus0.in_valid = 1'b0;
      chk_bit("abort_busy", busy0, 1'b0);
      chk_bit("abort_in_ready", bus0.in_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_bit("abort_no_out_valid", bus0.out_valid, 1'b0);
         chk_bit("abort_no_done", done0, 1'b0);
      end
      run("after_abort", xs, ws, 0, 1'b0, 0);

      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk_bit("start_abort_idle_busy", busy0, 1'b0);
      chk_bit("start_abort_idle_in_ready", bus0.in_ready, 1'b0);

      // reset mid-accumulation
      start_neuron(5);
      drive_beat(xs, ws, 0);
      tick();
      bus0.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_bit("midrst_in_ready", bus0.in_ready, 1'b0);
      chk_bit("midrst_busy", busy0, 1'b0);
      chk_val("midrst_out_data", 64'(bus0.out_data), 64'(0));
      chk_bit("midrst_out_valid", bus0.out_valid, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // back-to-back: next start issued in the done cycle
      for (int k = 0; k < N_IN; k++) begin xs2[k] = 7 - k; ws2[k] = -4 + k; end
      start_neuron(11);
      feed("b2b_first", xs, ws, 1'b0, e0);
      finish(0, e0);
      start_neuron(-20);
      feed("b2b_second", xs2, ws2, 1'b0, e0);
      finish(2, e0);
      tick();
      chk_bit("b2b_done_cleared", done0, 1'b0);

      // randomized neurons, mixing in-range and saturating magnitudes
      for (int n = 0; n < 16; n++) begin
         for (int k = 0; k < N_IN; k++) begin
            if (n % 2 == 0) xs[k] = int'($urandom_range(0, 4000)) - 2000;
            else            xs[k] = int'($urandom) >>> 2;
            ws[k] = int'($urandom_range(0, 511)) - 256;
         end
         run("random", xs, ws, int'($urandom_range(0, 511)) - 256,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
